// File: rtl/clk_meter_pkg.sv
// Shared types and default constants for the clock period meter.
package clk_meter_pkg;

  // Measurement state machine encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2,
    LOST    = 2'd3
  } meter_state_t;

  // Defaults match a divider with scaler=100: period 2*(100+1) i_clk cycles
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_EXP_PERIOD  = 202;
  localparam int DEF_TOL         = 2;
  localparam int DEF_LOCK_COUNT  = 2;
  localparam int DEF_TIMEOUT     = 1024;

endpackage

// File: rtl/sync_edge_det.sv
// Brings an asynchronous clock-like input into the i_clk domain and produces
// registered one-cycle rise/fall pulses. Pulses lag the pin by SYNC_STAGES+1.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic nreset_i,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Metastability chain: i_async enters at bit 0 and shifts toward the MSB
  always_ff @(posedge i_clk or negedge nreset_i) begin
    if (!nreset_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  // Edge detect on the synchronized level, pulses registered for clean timing
  always_ff @(posedge i_clk or negedge nreset_i) begin
    if (!nreset_i) begin
      r_prev <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_prev <= w_sync;
      o_rise <= w_sync & ~r_prev;
      o_fall <= ~w_sync & r_prev;
    end
  end

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in i_clk cycles,
// reports lock against an expected period and flags loss of the clock.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int EXP_PERIOD  = DEF_EXP_PERIOD,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             nreset_i,
  input  logic             i_meas_clk,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_lost
);

  localparam int CW1 = CNT_W + 1;
  localparam int LW  = $clog2(LOCK_COUNT + 1);
  // Tolerance window evaluated one bit wider so EXP_PERIOD+TOL cannot wrap;
  // the low bound clamps at zero when TOL exceeds EXP_PERIOD
  localparam logic [CW1-1:0]   TOL_LO   = (TOL > EXP_PERIOD) ? '0 : CW1'(EXP_PERIOD - TOL);
  localparam logic [CW1-1:0]   TOL_HI   = CW1'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_COUNT);

  meter_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high;
  logic [LW-1:0]    r_lock_cnt;

  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_in_tol;
  logic             w_timeout;
  logic [LW-1:0]    w_lock_inc;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .i_clk    (i_clk),
    .nreset_i (nreset_i),
    .i_async  (i_meas_clk),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  // Saturating count+1 doubles as the captured distance on an edge cycle
  always_comb begin
    w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    w_in_tol   = ({1'b0, w_cnt_inc} >= TOL_LO) && ({1'b0, w_cnt_inc} <= TOL_HI);
    w_timeout  = (r_cnt == TO_LAST);
    w_lock_inc = (r_lock_cnt == LOCK_MAX) ? LOCK_MAX : r_lock_cnt + 1'b1;
  end

  // Measurement FSM with all outputs registered; a rise always beats a timeout
  always_ff @(posedge i_clk or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_high      <= '0;
      r_lock_cnt  <= '0;
      o_period    <= '0;
      o_high_time <= '0;
      o_valid     <= 1'b0;
      o_locked    <= 1'b0;
      o_lost      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_enable) begin
        // Disabled: drop any partial measurement, keep last published results
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_high     <= '0;
        r_lock_cnt <= '0;
        o_locked   <= 1'b0;
        o_lost     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= ACQUIRE;
            r_cnt   <= '0;
          end
          ACQUIRE: begin
            if (w_rise) begin
              r_state <= MEASURE;
              r_cnt   <= '0;
              r_high  <= '0;
            end else if (w_timeout) begin
              r_state    <= LOST;
              r_cnt      <= w_cnt_inc;
              r_lock_cnt <= '0;
              o_locked   <= 1'b0;
              o_lost     <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          MEASURE: begin
            if (w_rise) begin
              r_cnt       <= '0;
              o_period    <= w_cnt_inc;
              o_high_time <= r_high;
              o_valid     <= 1'b1;
              if (w_in_tol) begin
                r_lock_cnt <= w_lock_inc;
                if (w_lock_inc == LOCK_MAX) o_locked <= 1'b1;
              end else begin
                r_lock_cnt <= '0;
                o_locked   <= 1'b0;
              end
            end else if (w_timeout) begin
              r_state    <= LOST;
              r_cnt      <= w_cnt_inc;
              r_lock_cnt <= '0;
              o_locked   <= 1'b0;
              o_lost     <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
              if (w_fall) r_high <= w_cnt_inc;
            end
          end
          LOST: begin
            // The rise that ends LOST is also the acquisition rise, so the
            // first new o_valid arrives on the following rise
            if (w_rise) begin
              r_state <= MEASURE;
              r_cnt   <= '0;
              r_high  <= '0;
              o_lost  <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: lock, off-frequency, loss, recovery,
// glitch period, enable drop and asynchronous reset.
module tb_clk_period_meter;

  localparam int CNT_W      = 32;
  localparam int TIMEOUT    = 1024;

  logic             clk;
  logic             nreset_i;
  logic             i_meas_clk;
  logic             i_enable;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high_time;
  logic             o_valid;
  logic             o_locked;
  logic             o_lost;

  int n_checks = 0;
  int n_errors = 0;

  // Divided-clock generator controls (counts in i_clk cycles)
  bit gen_run    = 1'b0;
  int gen_hi     = 101;
  int gen_lo     = 101;
  int gen_inject = 0;
  int gh;
  int gl;

  int cyc            = 0;
  int last_valid_cyc = 0;
  int valid_count    = 0;

  clk_period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .EXP_PERIOD  (202),
    .TOL         (2),
    .LOCK_COUNT  (2),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .nreset_i    (nreset_i),
    .i_meas_clk  (i_meas_clk),
    .i_enable    (i_enable),
    .o_period    (o_period),
    .o_high_time (o_high_time),
    .o_valid     (o_valid),
    .o_locked    (o_locked),
    .o_lost      (o_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Track o_valid strobes for latency and absence checks
  always @(negedge clk) begin
    if (o_valid) begin
      last_valid_cyc = cyc;
      valid_count    = valid_count + 1;
    end
  end

  // Measured clock, edges placed on i_clk falling edges; an injected period
  // uses 105/105 once
  always begin
    if (!gen_run) begin
      i_meas_clk = 1'b0;
      @(negedge clk);
    end else begin
      gh = gen_hi;
      gl = gen_lo;
      if (gen_inject > 0) begin
        gh = 105;
        gl = 105;
        gen_inject = gen_inject - 1;
      end
      i_meas_clk = 1'b1;
      repeat (gh) @(negedge clk);
      i_meas_clk = 1'b0;
      repeat (gl) @(negedge clk);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_valid && n < max_cyc);
    if (!o_valid) check({tag, "_valid_timeout"}, 0, 1);
  endtask

  initial begin
    int c0;
    int v0;
    int n;
    nreset_i = 1'b0;
    i_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", o_period, 0);
    check("rst_high", o_high_time, 0);
    check("rst_valid", o_valid, 0);
    check("rst_locked", o_locked, 0);
    check("rst_lost", o_lost, 0);
    nreset_i = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal divider: period 202, high 101, lock on 2nd valid
    i_enable = 1'b1;
    repeat (5) @(negedge clk);
    gen_hi  = 101;
    gen_lo  = 101;
    gen_run = 1'b1;
    wait_valid("v1", 800);
    check("v1_period", o_period, 202);
    check("v1_high", o_high_time, 101);
    check("v1_locked", o_locked, 0);
    wait_valid("v2", 400);
    check("v2_period", o_period, 202);
    check("v2_locked", o_locked, 1);

    // Stop the clock: lost exactly TIMEOUT cycles after the last valid
    gen_run = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_lost && n < 3000);
    check("lost_seen", o_lost, 1);
    check("lost_delay", cyc - last_valid_cyc, TIMEOUT);
    check("lost_locked", o_locked, 0);

    // Restart: lost clears on 1st rise, first valid 202 cycles later
    gen_run = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_lost && n < 50);
    check("restart_lost_clear", o_lost, 0);
    c0 = cyc;
    wait_valid("r1", 400);
    check("r1_delay", cyc - c0, 202);
    check("r1_period", o_period, 202);
    check("r1_locked", o_locked, 0);
    wait_valid("r2", 400);
    check("r2_locked", o_locked, 1);

    // One 210 period: lock drops on it, returns after two good periods
    gen_inject = 1;
    wait_valid("g1", 400);
    check("g1_period", o_period, 202);
    check("g1_locked", o_locked, 1);
    wait_valid("g2", 400);
    check("g2_period", o_period, 210);
    check("g2_high", o_high_time, 105);
    check("g2_locked", o_locked, 0);
    wait_valid("g3", 400);
    check("g3_locked", o_locked, 0);
    wait_valid("g4", 400);
    check("g4_period", o_period, 202);
    check("g4_locked", o_locked, 1);

    // Scaler 150: period 302 never locks
    gen_hi = 151;
    gen_lo = 151;
    wait_valid("s0", 400);
    check("s0_period", o_period, 202);
    wait_valid("s1", 400);
    check("s1_period", o_period, 302);
    check("s1_high", o_high_time, 151);
    check("s1_locked", o_locked, 0);
    wait_valid("s2", 400);
    check("s2_period", o_period, 302);
    check("s2_locked", o_locked, 0);

    // Disable mid-period: results hold, flags clear, no further valids
    repeat (50) @(negedge clk);
    i_enable = 1'b0;
    repeat (3) @(negedge clk);
    v0 = valid_count;
    check("dis_period", o_period, 302);
    check("dis_high", o_high_time, 151);
    check("dis_locked", o_locked, 0);
    check("dis_lost", o_lost, 0);
    repeat (700) @(negedge clk);
    check("dis_no_valid", valid_count - v0, 0);

    // Asynchronous reset between clock edges clears everything at once
    #3;
    nreset_i = 1'b0;
    #1;
    check("arst_period", o_period, 0);
    check("arst_high", o_high_time, 0);
    check("arst_valid", o_valid, 0);
    check("arst_locked", o_locked, 0);
    check("arst_lost", o_lost, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
